// File: rtl/ram_capture_writer.sv
// ram_capture_writer: captures a stream of WIDTH-bit samples into a DEPTH-entry
// RAM at consecutive addresses, then stops when the buffer is full.
//
// Ports:
//   clk       - single clock, all logic on rising edge
//   rst       - synchronous active-high reset
//   start     - capture request (honoured in IDLE and DONE)
//   wen       - sample-valid tick, qualifies din
//   din       - sample data
//   busy      - high while capturing
//   done      - high while the buffer is full
//   wr_count  - samples written in the current capture, 0..DEPTH
//   ren       - read enable
//   raddr     - read address
//   dout      - registered read data, 1-cycle latency, read-first on collision
module ram_capture_writer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       wen,
  input  logic [WIDTH-1:0]           din,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH):0]     wr_count,
  input  logic                       ren,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]           dout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t           r_state;
  logic [AW-1:0]    r_waddr;
  logic [CW-1:0]    r_wr_count;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_dout;
  logic [WIDTH-1:0] r_mem [DEPTH];

  state_t           w_state_nxt;
  logic [AW-1:0]    w_waddr_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic             w_we;

  // Next-state, write pointer and write strobe
  always_comb begin
    w_state_nxt = r_state;
    w_waddr_nxt = r_waddr;
    w_count_nxt = r_wr_count;
    w_we        = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        // wen is deliberately ignored here, including in the start cycle
        if (start) begin
          w_state_nxt = S_CAPTURE;
          w_waddr_nxt = '0;
          w_count_nxt = '0;
        end
      end
      S_CAPTURE: begin
        if (wen) begin
          w_we        = 1'b1;
          w_count_nxt = r_wr_count + CW'(1);
          // Explicit wrap so non-power-of-two depths behave the same way
          if (r_waddr == LAST_ADDR) begin
            w_waddr_nxt = '0;
            w_state_nxt = S_DONE;
          end else begin
            w_waddr_nxt = r_waddr + AW'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_waddr    <= '0;
      r_wr_count <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_waddr    <= w_waddr_nxt;
      r_wr_count <= w_count_nxt;
      r_busy     <= (w_state_nxt == S_CAPTURE);
      r_done     <= (w_state_nxt == S_DONE);
    end
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (w_we && !rst) begin
      r_mem[r_waddr] <= din;
    end
  end

  // Synchronous read port; non-blocking update gives read-first on collision
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout <= '0;
    end else if (ren) begin
      r_dout <= r_mem[raddr];
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign wr_count = r_wr_count;
  assign dout     = r_dout;

endmodule
